// File: rtl/pipelined_control_unit_if.sv
// Bundles the D-stage inputs and the E/M/W-stage and hazard outputs of pipelined_control_unit.
// The master side drives the decode inputs; the slave side is the control unit.
interface pipelined_control_unit_if #(
  parameter int OPCODEWIDTH   = 4,
  parameter int REGADDRWIDTH  = 4,
  parameter int STALLCNTWIDTH = 16
);
  logic [OPCODEWIDTH-1:0]   opcodeD;
  logic [REGADDRWIDTH-1:0]  rs1D;
  logic [REGADDRWIDTH-1:0]  rs2D;
  logic [REGADDRWIDTH-1:0]  rdD;
  logic                     branchTakenE;
  logic                     stallExt;

  logic                     obtainPCAsR1E;
  logic                     data2SelectorE;
  logic                     outFlagE;
  logic [2:0]               aluControlE;
  logic                     writeDataEnableM;
  logic                     resultSelectorW;
  logic                     writeEnableW;
  logic [REGADDRWIDTH-1:0]  rdW;
  logic                     illegalE;
  logic                     stallF;
  logic                     stallD;
  logic                     flushD;
  logic                     flushE;
  logic [1:0]               forwardAE;
  logic [1:0]               forwardBE;
  logic [STALLCNTWIDTH-1:0] stallCount;

  modport master (
    output opcodeD, rs1D, rs2D, rdD, branchTakenE, stallExt,
    input  obtainPCAsR1E, data2SelectorE, outFlagE, aluControlE, writeDataEnableM,
           resultSelectorW, writeEnableW, rdW, illegalE, stallF, stallD, flushD, flushE,
           forwardAE, forwardBE, stallCount
  );

  modport slave (
    input  opcodeD, rs1D, rs2D, rdD, branchTakenE, stallExt,
    output obtainPCAsR1E, data2SelectorE, outFlagE, aluControlE, writeDataEnableM,
           resultSelectorW, writeEnableW, rdW, illegalE, stallF, stallD, flushD, flushE,
           forwardAE, forwardBE, stallCount
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// 5-stage pipeline control: D decode, E/M/W control registers (1/2/3 cycles), hazard stall/flush.
// stallExt freezes every stage; CONTROLUNIT_FORWARD_EN enables E-stage forwarding so only load-use stalls.
module pipelined_control_unit #(
  parameter int OPCODEWIDTH   = 4,
  parameter int REGADDRWIDTH  = 4,
  parameter int STALLCNTWIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  pipelined_control_unit_if.slave bus
);

  typedef struct packed {
    logic                    we;
    logic                    resSel;
    logic                    memWe;
    logic                    d2;
    logic                    pcR1;
    logic                    out;
    logic [2:0]              alu;
    logic                    illegal;
    logic [REGADDRWIDTH-1:0] rd;
  } ctl_t;

  ctl_t                     w_dec;
  ctl_t                     r_e;
  logic                     r_m_we;
  logic                     r_m_resSel;
  logic                     r_m_memWe;
  logic [REGADDRWIDTH-1:0]  r_m_rd;
  logic                     r_w_we;
  logic                     r_w_resSel;
  logic [REGADDRWIDTH-1:0]  r_w_rd;
  logic [STALLCNTWIDTH-1:0] r_cnt;

  logic       w_illegal;
  logic [3:0] w_opc;
  logic       w_rs1_used;
  logic       w_rs2_used;
  logic       w_match_e;
  logic       w_hazard;
  logic       w_stallF;
  logic       w_stallD;
  logic       w_flushD;
  logic       w_flushE;

  generate
    if (OPCODEWIDTH > 4) begin : g_wide_opc
      assign w_illegal = |bus.opcodeD[OPCODEWIDTH-1:4];
    end else begin : g_narrow_opc
      assign w_illegal = 1'b0;
    end
  endgenerate

  assign w_opc = bus.opcodeD[3:0];

  always_comb begin
    w_dec = '0;
    if (w_illegal) begin
      w_dec.illegal = 1'b1;
    end else begin
      w_dec.rd = bus.rdD;
      case (w_opc)
        4'd0: begin w_dec.we = 1'b1; w_dec.alu = 3'b110; w_dec.resSel = 1'b1; end
        4'd1: begin w_dec.alu = 3'b110; w_dec.memWe = 1'b1; end
        4'd2: begin w_dec.we = 1'b1; w_dec.d2 = 1'b1; w_dec.alu = 3'b111; end
        4'd3: begin w_dec.we = 1'b1; w_dec.alu = 3'b110; end
        4'd4: begin w_dec.alu = 3'b110; w_dec.out = 1'b1; end
        4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin w_dec.we = 1'b1; w_dec.alu = 3'b000; end
        4'd10: begin w_dec.alu = 3'b001; end
        default: begin w_dec.pcR1 = 1'b1; w_dec.d2 = 1'b1; w_dec.alu = 3'b000; end
      endcase
    end
  end

  assign w_rs1_used = ~w_dec.pcR1;
  assign w_rs2_used = ~w_illegal & ((w_opc == 4'd1) | ((w_opc >= 4'd5) & (w_opc <= 4'd10)));

  assign w_match_e = r_e.we & ((w_rs1_used & (r_e.rd == bus.rs1D)) |
                               (w_rs2_used & (r_e.rd == bus.rs2D)));

`ifdef CONTROLUNIT_FORWARD_EN
  logic [REGADDRWIDTH-1:0] r_e_rs1;
  logic [REGADDRWIDTH-1:0] r_e_rs2;
  logic [1:0]              w_fwdA;
  logic [1:0]              w_fwdB;

  assign w_hazard = w_match_e & r_e.resSel;

  // M is the younger producer, so it wins over W.
  always_comb begin
    w_fwdA = 2'b00;
    w_fwdB = 2'b00;
    if (r_m_we && (r_m_rd == r_e_rs1))      w_fwdA = 2'b10;
    else if (r_w_we && (r_w_rd == r_e_rs1)) w_fwdA = 2'b01;
    if (r_m_we && (r_m_rd == r_e_rs2))      w_fwdB = 2'b10;
    else if (r_w_we && (r_w_rd == r_e_rs2)) w_fwdB = 2'b01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e_rs1 <= '0;
      r_e_rs2 <= '0;
    end else if (!bus.stallExt) begin
      r_e_rs1 <= (w_flushE || w_illegal) ? '0 : bus.rs1D;
      r_e_rs2 <= (w_flushE || w_illegal) ? '0 : bus.rs2D;
    end
  end

  assign bus.forwardAE = w_fwdA;
  assign bus.forwardBE = w_fwdB;
`else
  logic w_match_m;

  // Without forwarding a consumer waits until its producer has reached W (write-through).
  assign w_match_m = r_m_we & ((w_rs1_used & (r_m_rd == bus.rs1D)) |
                               (w_rs2_used & (r_m_rd == bus.rs2D)));
  assign w_hazard  = w_match_e | w_match_m;

  assign bus.forwardAE = 2'b00;
  assign bus.forwardBE = 2'b00;
`endif

  // Priority: reset, external freeze, taken branch, data hazard.
  always_comb begin
    w_stallF = 1'b0;
    w_stallD = 1'b0;
    w_flushD = 1'b0;
    w_flushE = 1'b0;
    if (!reset) begin
      if (bus.stallExt) begin
        w_stallF = 1'b1;
        w_stallD = 1'b1;
      end else if (bus.branchTakenE) begin
        w_flushD = 1'b1;
        w_flushE = 1'b1;
      end else if (w_hazard) begin
        w_stallF = 1'b1;
        w_stallD = 1'b1;
        w_flushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e        <= '0;
      r_m_we     <= 1'b0;
      r_m_resSel <= 1'b0;
      r_m_memWe  <= 1'b0;
      r_m_rd     <= '0;
      r_w_we     <= 1'b0;
      r_w_resSel <= 1'b0;
      r_w_rd     <= '0;
      r_cnt      <= '0;
    end else begin
      if (!bus.stallExt) begin
        r_e        <= w_flushE ? '0 : w_dec;
        r_m_we     <= r_e.we;
        r_m_resSel <= r_e.resSel;
        r_m_memWe  <= r_e.memWe;
        r_m_rd     <= r_e.rd;
        r_w_we     <= r_m_we;
        r_w_resSel <= r_m_resSel;
        r_w_rd     <= r_m_rd;
      end
      if (w_stallD && (r_cnt != '1)) r_cnt <= r_cnt + STALLCNTWIDTH'(1);
    end
  end

  assign bus.obtainPCAsR1E    = r_e.pcR1;
  assign bus.data2SelectorE   = r_e.d2;
  assign bus.outFlagE         = r_e.out;
  assign bus.aluControlE      = r_e.alu;
  assign bus.illegalE         = r_e.illegal;
  assign bus.writeDataEnableM = r_m_memWe;
  assign bus.resultSelectorW  = r_w_resSel;
  assign bus.writeEnableW     = r_w_we;
  assign bus.rdW              = r_w_rd;
  assign bus.stallF           = w_stallF;
  assign bus.stallD           = w_stallD;
  assign bus.flushD           = w_flushD;
  assign bus.flushE           = w_flushE;
  assign bus.stallCount       = r_cnt;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed vector table, random stimulus against an instruction-level model, and a 5-bit-opcode instance.
module tb_pipelined_control_unit;

`ifdef CONTROLUNIT_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic reset;
  logic reset5;

  pipelined_control_unit_if bus ();
  pipelined_control_unit_if #(.OPCODEWIDTH(5), .STALLCNTWIDTH(4)) bus5 ();

  pipelined_control_unit dut (.clk(clk), .reset(reset), .bus(bus));
  pipelined_control_unit #(.OPCODEWIDTH(5), .STALLCNTWIDTH(4)) dut5 (.clk(clk), .reset(reset5), .bus(bus5));

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Directed vectors; *_nf columns hold the no-forwarding expectation, *_f the forwarding one.
  typedef struct {
    bit rst; int op, rs1, rs2, rd; bit br, ext;
    bit snf, sf, fenf, fef, fd; int alu; bit mem, we; int fa, cnf, cf;
  } vec_t;

  function automatic vec_t mk(bit rst, int op, int rs1, int rs2, int rd, bit br, bit ext,
                              bit snf, bit sf, bit fenf, bit fef, bit fd, int alu, bit mem,
                              bit we, int fa, int cnf, int cf);
    vec_t v;
    v.rst = rst; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.br = br; v.ext = ext;
    v.snf = snf; v.sf = sf; v.fenf = fenf; v.fef = fef; v.fd = fd; v.alu = alu;
    v.mem = mem; v.we = we; v.fa = fa; v.cnf = cnf; v.cf = cf;
    return v;
  endfunction

  typedef struct {
    bit we, rs, mw, d2, pc, out, ill;
    int alu, rd, rs1, rs2;
  } ins_t;

  function automatic ins_t dec(int op, int rs1, int rs2, int rd);
    ins_t r = '{default: 0};
    if (op >= 16) begin
      r.ill = 1;
      return r;
    end
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    if (op == 0)       begin r.we = 1; r.alu = 6; r.rs = 1; end
    else if (op == 1)  begin r.alu = 6; r.mw = 1; end
    else if (op == 2)  begin r.we = 1; r.d2 = 1; r.alu = 7; end
    else if (op == 3)  begin r.we = 1; r.alu = 6; end
    else if (op == 4)  begin r.alu = 6; r.out = 1; end
    else if (op <= 9)  begin r.we = 1; r.alu = 0; end
    else if (op == 10) begin r.alu = 1; end
    else               begin r.pc = 1; r.d2 = 1; r.alu = 0; end
    return r;
  endfunction

  function automatic bit depends(ins_t p, int op, int rs1, int rs2, bit pc);
    bit u2 = (op == 1) || (op >= 5 && op <= 10);
    return p.we && ((!pc && p.rd == rs1) || (u2 && p.rd == rs2));
  endfunction

  function automatic int fwd_sel(ins_t m, ins_t w, int rs);
    if (!FWD) return 0;
    if (m.we && m.rd == rs) return 2;
    if (w.we && w.rd == rs) return 1;
    return 0;
  endfunction

  vec_t tbl[22];

  initial begin
    ins_t mE, mM, mW, d, bub;
    bit rst, br, ext, haz, eSt, eFD, eFE;
    int op, rs1, rs2, rd, mcnt;

    tbl[0]  = mk(0, 5, 1, 2, 4,   0,0, 0,0,0,0,0, 0,0,0,0, 0,0);
    tbl[1]  = mk(0, 1, 5, 6, 0,   0,0, 0,0,0,0,0, 0,0,0,0, 0,0);
    tbl[2]  = mk(0, 3, 7, 7, 8,   0,0, 0,0,0,0,0, 6,0,0,0, 0,0);
    tbl[3]  = mk(0,10, 9,10, 0,   0,0, 0,0,0,0,0, 6,1,1,0, 0,0);
    tbl[4]  = mk(0, 0, 1, 0, 3,   0,0, 0,0,0,0,0, 1,0,0,0, 0,0);
    tbl[5]  = mk(0, 5, 3,11,12,   0,0, 1,1,1,1,0, 6,0,1,0, 0,0);
    tbl[6]  = mk(0, 5, 3,11,12,   0,0, 1,0,1,0,0, 0,0,0,0, 1,1);
    tbl[7]  = mk(0, 5, 3,11,12,   0,0, 0,0,0,0,0, 0,0,1,1, 2,1);
    tbl[8]  = mk(1, 5,12,12,12,   0,1, 0,0,0,0,0, 0,0,0,0, 0,0);
    tbl[9]  = mk(0, 5, 1, 1, 2,   0,0, 0,0,0,0,0, 0,0,0,0, 0,0);
    tbl[10] = mk(0, 5, 2, 5, 6,   0,0, 1,0,1,0,0, 0,0,0,0, 0,0);
    tbl[11] = mk(0, 5, 2, 5, 6,   0,0, 1,0,1,0,0, 0,0,0,2, 1,0);
    tbl[12] = mk(0, 5, 2, 5, 6,   0,0, 0,0,0,0,0, 0,0,1,1, 2,0);
    tbl[13] = mk(1, 0, 0, 0, 0,   0,0, 0,0,0,0,0, 0,0,0,0, 0,0);
    tbl[14] = mk(0, 0, 0, 0, 9,   0,0, 0,0,0,0,0, 0,0,0,0, 0,0);
    tbl[15] = mk(0, 5, 9, 9, 1,   1,0, 0,0,1,1,1, 6,0,0,0, 0,0);
    tbl[16] = mk(0, 5, 9, 9, 1,   0,0, 1,0,1,0,0, 0,0,0,0, 0,0);
    tbl[17] = mk(0, 5, 9, 9, 1,   0,1, 1,1,0,0,0, 0,0,1,1, 1,0);
    tbl[18] = mk(0, 5, 9, 9, 1,   0,1, 1,1,0,0,0, 0,0,1,1, 2,1);
    tbl[19] = mk(0, 5, 9, 9, 1,   1,1, 1,1,0,0,0, 0,0,1,1, 3,2);
    tbl[20] = mk(0, 5, 9, 9, 1,   1,0, 0,0,1,1,1, 0,0,1,1, 4,3);
    tbl[21] = mk(1, 0, 0, 0, 0,   0,1, 0,0,0,0,0, 0,0,0,0, 0,0);

    clk = 0; reset = 1; reset5 = 1;
    bus.opcodeD = '0; bus.rs1D = '0; bus.rs2D = '0; bus.rdD = '0;
    bus.branchTakenE = 0; bus.stallExt = 0;
    bus5.opcodeD = '0; bus5.rs1D = '0; bus5.rs2D = '0; bus5.rdD = '0;
    bus5.branchTakenE = 0; bus5.stallExt = 0;

    @(posedge clk); #1;
    chk("rst_stallCount", 32'(bus.stallCount), 0);
    chk("rst_weW", 32'(bus.writeEnableW), 0);
    chk("rst_aluE", 32'(bus.aluControlE), 0);
    chk("rst_stallD", 32'(bus.stallD), 0);

    for (int i = 0; i < 22; i++) begin
      reset = tbl[i].rst;
      bus.opcodeD = 4'(tbl[i].op); bus.rs1D = 4'(tbl[i].rs1);
      bus.rs2D = 4'(tbl[i].rs2);   bus.rdD = 4'(tbl[i].rd);
      bus.branchTakenE = tbl[i].br; bus.stallExt = tbl[i].ext;
      #3;
      eSt = FWD ? tbl[i].sf : tbl[i].snf;
      eFE = FWD ? tbl[i].fef : tbl[i].fenf;
      chk($sformatf("v%0d_stallF", i), 32'(bus.stallF), 32'(eSt));
      chk($sformatf("v%0d_stallD", i), 32'(bus.stallD), 32'(eSt));
      chk($sformatf("v%0d_flushD", i), 32'(bus.flushD), 32'(tbl[i].fd));
      chk($sformatf("v%0d_flushE", i), 32'(bus.flushE), 32'(eFE));
      chk($sformatf("v%0d_aluE", i), 32'(bus.aluControlE), 32'(tbl[i].alu));
      chk($sformatf("v%0d_memWeM", i), 32'(bus.writeDataEnableM), 32'(tbl[i].mem));
      chk($sformatf("v%0d_weW", i), 32'(bus.writeEnableW), 32'(tbl[i].we));
      chk($sformatf("v%0d_fwdA", i), 32'(bus.forwardAE), FWD ? 32'(tbl[i].fa) : 0);
      chk($sformatf("v%0d_stallCount", i), 32'(bus.stallCount), FWD ? 32'(tbl[i].cf) : 32'(tbl[i].cnf));
      @(posedge clk); #1;
    end

    // Random phase; the last vector left the pipeline reset.
    bub = '{default: 0};
    mE = bub; mM = bub; mW = bub; mcnt = 0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      br  = ($urandom_range(0, 9) == 0);
      ext = ($urandom_range(0, 9) == 0);
      op  = $urandom_range(0, 15);
      rs1 = $urandom_range(0, 5);
      rs2 = $urandom_range(0, 5);
      rd  = $urandom_range(0, 5);
      reset = rst; bus.branchTakenE = br; bus.stallExt = ext;
      bus.opcodeD = 4'(op); bus.rs1D = 4'(rs1); bus.rs2D = 4'(rs2); bus.rdD = 4'(rd);
      if (rst) begin mE = bub; mM = bub; mW = bub; mcnt = 0; end
      d = dec(op, rs1, rs2, rd);
      if (FWD) haz = mE.rs && depends(mE, op, rs1, rs2, d.pc);
      else     haz = depends(mE, op, rs1, rs2, d.pc) || depends(mM, op, rs1, rs2, d.pc);
      eSt = !rst && (ext || (!br && haz));
      eFD = !rst && !ext && br;
      eFE = !rst && !ext && (br || haz);
      #3;
      chk("r_stallF", 32'(bus.stallF), 32'(eSt));
      chk("r_stallD", 32'(bus.stallD), 32'(eSt));
      chk("r_flushD", 32'(bus.flushD), 32'(eFD));
      chk("r_flushE", 32'(bus.flushE), 32'(eFE));
      chk("r_pcR1E", 32'(bus.obtainPCAsR1E), 32'(mE.pc));
      chk("r_d2E", 32'(bus.data2SelectorE), 32'(mE.d2));
      chk("r_outE", 32'(bus.outFlagE), 32'(mE.out));
      chk("r_aluE", 32'(bus.aluControlE), 32'(mE.alu));
      chk("r_illegalE", 32'(bus.illegalE), 32'(mE.ill));
      chk("r_memWeM", 32'(bus.writeDataEnableM), 32'(mM.mw));
      chk("r_resSelW", 32'(bus.resultSelectorW), 32'(mW.rs));
      chk("r_weW", 32'(bus.writeEnableW), 32'(mW.we));
      chk("r_rdW", 32'(bus.rdW), 32'(mW.rd));
      chk("r_fwdA", 32'(bus.forwardAE), 32'(fwd_sel(mM, mW, mE.rs1)));
      chk("r_fwdB", 32'(bus.forwardBE), 32'(fwd_sel(mM, mW, mE.rs2)));
      chk("r_stallCount", 32'(bus.stallCount), 32'(mcnt));
      if (!rst && !ext) begin
        mW = mM; mM = mE;
        mE = eFE ? bub : d;
      end
      if (eSt && mcnt < 65535) mcnt++;
      @(posedge clk); #1;
    end
    reset = 0;

    // 5-bit opcode instance: illegal encodings and a 4-bit saturating counter.
    bus5.opcodeD = 5'd16; bus5.rs1D = 4'd1; bus5.rs2D = 4'd1; bus5.rdD = 4'd7;
    reset5 = 0;
    @(posedge clk); #1;
    bus5.opcodeD = 5'd2; bus5.rs1D = 4'd3; bus5.rdD = 4'd5;
    #3;
    chk("w5_illegalE", 32'(bus5.illegalE), 1);
    chk("w5_ill_aluE", 32'(bus5.aluControlE), 0);
    chk("w5_ill_pcR1E", 32'(bus5.obtainPCAsR1E), 0);
    chk("w5_ill_d2E", 32'(bus5.data2SelectorE), 0);
    chk("w5_ill_outE", 32'(bus5.outFlagE), 0);
    @(posedge clk); #1;
    bus5.opcodeD = 5'd5; bus5.rs1D = 4'd3; bus5.rdD = 4'd6;
    #3;
    chk("w5_imm_illegalE", 32'(bus5.illegalE), 0);
    chk("w5_imm_d2E", 32'(bus5.data2SelectorE), 1);
    chk("w5_imm_aluE", 32'(bus5.aluControlE), 7);
    chk("w5_ill_memWeM", 32'(bus5.writeDataEnableM), 0);
    @(posedge clk); #1;
    bus5.opcodeD = 5'd31; bus5.rs1D = 4'd1;
    #3;
    chk("w5_ill_weW", 32'(bus5.writeEnableW), 0);
    chk("w5_ill_rdW", 32'(bus5.rdW), 0);
    @(posedge clk); #1;
    bus5.stallExt = 1;
    #3;
    chk("w5_cnt_before", 32'(bus5.stallCount), 0);
    chk("w5_ext_stallF", 32'(bus5.stallF), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("w5_cnt_ext3", 32'(bus5.stallCount), 3);
    chk("w5_ext_aluE", 32'(bus5.aluControlE), 0);
    chk("w5_ext_weW", 32'(bus5.writeEnableW), 1);
    repeat (14) @(posedge clk);
    #1;
    chk("w5_cnt_sat", 32'(bus5.stallCount), 15);
    @(posedge clk); #1;
    chk("w5_cnt_nowrap", 32'(bus5.stallCount), 15);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation control unit for the 5-stage pipeline.
- Decodes the opcode in D and carries the control bundle through the E, M and W stage registers.
- Detects RAW/load-use hazards and generates stall/flush for the F/D/E stages.
- Optionally generates E-stage operand forwarding selects and keeps a saturating stall-cycle counter.

Parameters:
- OPCODEWIDTH, 4, opcode width; encodings at or above 16 are illegal.
- REGADDRWIDTH, 4, register address width.
- STALLCNTWIDTH, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all stage registers and the counter
- opcodeD  in  OPCODEWIDTH  D-stage opcode
- rs1D, rs2D, rdD  in  REGADDRWIDTH each  D-stage source and destination registers
- branchTakenE  in  1  branch in E resolved as taken
- stallExt  in  1  external freeze (memory wait)
- obtainPCAsR1E, data2SelectorE, outFlagE  out  1 each  E-stage controls
- aluControlE  out  3  E-stage ALU operation
- writeDataEnableM  out  1  M-stage memory write enable
- resultSelectorW, writeEnableW  out  1 each  W-stage controls
- rdW  out  REGADDRWIDTH  W-stage destination
- illegalE  out  1  E-stage instruction had an illegal opcode
- stallF, stallD, flushD, flushE  out  1 each  hazard controls
- forwardAE, forwardBE  out  2 each  forwarding selects (FORWARD_EN only)
- stallCount  out  STALLCNTWIDTH  saturating stall-cycle count

Behaviour:
- Decode (combinational in D). Every unlisted field is 0; no X values are produced.
  - 0000 LOAD: we=1, alu=110, resSel=1.
  - 0001 STORE: alu=110, memWe=1.
  - 0010 IMM: we=1, d2=1, alu=111.
  - 0011 MOV: we=1, alu=110.
  - 0100 OUT: alu=110, out=1.
  - 0101-1001 ALU: we=1, alu=000.
  - 1010 CMP: alu=001.
  - 1011-1111 BRANCH: pcR1=1, d2=1, alu=000.
  - Opcode >= 16: all zero, with illegal=1 carried to illegalE.
- Source use:
  - rs1 is used unless pcR1=1.
  - rs2 is used for ALU, CMP and STORE.
- Stage registers:
  - D->E, E->M and M->W all update on the rising edge of clk.
  - Bubble = all controls 0 and rd=0.
  - Asynchronous reset forces every stage to bubble and stallCount to 0.
  - After reset every output is 0.
- Latency: a decoded control appears on the E outputs 1 cycle after D, the M output 2 cycles after, and the W outputs 3 cycles after.
- Load-use hazard:
  - Condition: E holds LOAD (resSelE & weE) and rdE matches a used rs of D.
  - Response: stallF=stallD=1, flushE=1. A bubble enters E while D holds.
- Branch:
  - branchTakenE=1 gives flushD=flushE=1.
  - stallF=stallD=0 that cycle. Branch overrides load-use.
- stallExt=1:
  - All stage registers hold and no bubbles are inserted.
  - stallF=stallD=1, flushD=flushE=0.
  - stallExt overrides branch and hazard; the branch is acted on when stallExt drops.
- stallCount:
  - Increments once per cycle where stallD=1, from any cause.
  - Saturates at all-ones and never wraps.
- Register file is write-through, so a match against rdW never stalls.
- Reset asserted mid-stall: all stages are bubbles on the next cycle, and hazard outputs drop to 0 combinationally.

Optional Feature:
- Macro: CONTROLUNIT_FORWARD_EN.
- Defined:
  - rs1E and rs2E are registered internally.
  - forwardAE (and likewise forwardBE for rs2E):
    - 10 if weM and rdM==rs1E
    - else 01 if weW and rdW==rs1E
    - else 00
  - M takes priority over W.
  - Only load-use stalls.
- Undefined:
  - forwardAE and forwardBE are tied to 00.
  - Stall (as for load-use) whenever D uses rs equal to rdE with weE=1, or rdM with weM=1.
  - Stalls last until the producer reaches W.

Test Plan:
- Reset: assert reset mid-stream -> all outputs 0 immediately; stallCount=0.
- Pipeline flow: ALU 0101 then STORE 0001, independent regs -> aluControlE=000 at +1; writeDataEnableM=1 at +2 for the store; writeEnableW=1 at +3 for the ALU; no stalls.
- Load-use: LOAD rd=3, then ALU rs1=3 -> one cycle of stallF=stallD=flushE=1; stallCount=1; ALU reaches E one cycle late.
- Branch vs hazard: branchTakenE=1 while a load-use hazard is present -> flushD=flushE=1, stallD=0.
- stallExt held 3 cycles -> E/M/W outputs unchanged; stallCount +3.
- FORWARD_EN on: ALU rd=2, ALU rs1=2, ALU rs1=2 -> forwardAE=10, then 01, no stalls. FORWARD_EN off, same sequence -> 2 stall cycles. Separately, opcode 16 with OPCODEWIDTH=5 -> illegalE=1, all other controls 0.
